// File: rtl/stopwatch_defs.sv
// Shared stopwatch definitions: FSM state encodings, digit width and the BCD terminal digit.
package stopwatch_defs;

  localparam int STATE_W = 3;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'h9;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_LAP_RUN = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic all_nine(input logic [DIGIT_W-1:0] d1, input logic [DIGIT_W-1:0] d2,
                                    input logic [DIGIT_W-1:0] d3, input logic [DIGIT_W-1:0] d4);
    return (d1 == BCD_NINE) && (d2 == BCD_NINE) && (d3 == BCD_NINE) && (d4 == BCD_NINE);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> debounced level -> one-cycle press pulse on its rising edge.
// Press pulse is valid DEB_CYCLES+2 edges after the raw rise; no backpressure.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any sample agreeing with the current level restarts the stability run.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer for a 4-digit BCD counter: button FSM, tick prescaler, lap freeze, stop at 9999.
// CNT_EN/CNT_RST are registered one-cycle pulses; DISP outputs are combinational.
module stopwatch_ctrl
  import stopwatch_defs::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int DEB_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BTN_SS,
  input  logic               BTN_LAP,
  input  logic               BTN_CLR,
  input  logic [DIGIT_W-1:0] CNT_D1,
  input  logic [DIGIT_W-1:0] CNT_D2,
  input  logic [DIGIT_W-1:0] CNT_D3,
  input  logic [DIGIT_W-1:0] CNT_D4,
  output logic               CNT_EN,
  output logic               CNT_RST,
  output logic [DIGIT_W-1:0] DISP1,
  output logic [DIGIT_W-1:0] DISP2,
  output logic [DIGIT_W-1:0] DISP3,
  output logic [DIGIT_W-1:0] DISP4,
  output logic [STATE_W-1:0] STATE,
  output logic               RUNNING,
  output logic               OVF
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_presc;
  logic               r_cnt_en;
  logic               r_cnt_rst;
  logic [DIGIT_W-1:0] r_lap1;
  logic [DIGIT_W-1:0] r_lap2;
  logic [DIGIT_W-1:0] r_lap3;
  logic [DIGIT_W-1:0] r_lap4;

  logic w_ss;
  logic w_lap;
  logic w_clr;
  logic w_sel_ss;
  logic w_sel_lap;
  logic w_run;
  logic w_tick;
  logic w_terminal;
  logic w_lap_latch;
  logic w_clr_accept;
  logic w_presc_clear;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss  (.CLK(CLK), .RST(RST), .i_btn(BTN_SS),  .o_press(w_ss));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (.CLK(CLK), .RST(RST), .i_btn(BTN_LAP), .o_press(w_lap));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (.CLK(CLK), .RST(RST), .i_btn(BTN_CLR), .o_press(w_clr));

  // A higher-priority press drops the lower ones even if the state ignores it.
  assign w_sel_ss  = w_ss & ~w_clr;
  assign w_sel_lap = w_lap & ~w_ss & ~w_clr;

  assign w_run      = (r_state == ST_RUN) || (r_state == ST_LAP_RUN);
  assign w_tick     = w_run && (r_presc == PRESC_LAST);
  assign w_terminal = all_nine(CNT_D1, CNT_D2, CNT_D3, CNT_D4);

  always_comb begin
    w_state_nxt   = r_state;
    w_lap_latch   = 1'b0;
    w_clr_accept  = 1'b0;
    w_presc_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_clr) begin
          w_clr_accept = 1'b1;
        end else if (w_sel_ss) begin
          w_state_nxt   = ST_RUN;
          w_presc_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_tick && w_terminal) begin
          w_state_nxt = ST_DONE;
        end else if (w_sel_ss) begin
          w_state_nxt = ST_PAUSED;
        end else if (w_sel_lap) begin
          w_state_nxt = ST_LAP_RUN;
          w_lap_latch = 1'b1;
        end
      end
      ST_LAP_RUN: begin
        if (w_tick && w_terminal) begin
          w_state_nxt = ST_DONE;
        end else if (w_sel_ss) begin
          w_state_nxt = ST_PAUSED;
        end else if (w_sel_lap) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_PAUSED: begin
        if (w_clr) begin
          w_state_nxt  = ST_IDLE;
          w_clr_accept = 1'b1;
        end else if (w_sel_ss) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (w_clr) begin
          w_state_nxt  = ST_IDLE;
          w_clr_accept = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_cnt_en  <= 1'b0;
      r_cnt_rst <= 1'b1;
      r_lap1    <= '0;
      r_lap2    <= '0;
      r_lap3    <= '0;
      r_lap4    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt_en  <= w_tick && !w_terminal && !w_clr_accept;
      r_cnt_rst <= w_clr_accept;
      if (w_clr_accept || w_presc_clear) begin
        r_presc <= '0;
      end else if (w_run) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end
      // Snapshot is taken before any increment this tick would cause.
      if (w_lap_latch) begin
        r_lap1 <= CNT_D1;
        r_lap2 <= CNT_D2;
        r_lap3 <= CNT_D3;
        r_lap4 <= CNT_D4;
      end
    end
  end

  assign CNT_EN  = r_cnt_en;
  assign CNT_RST = r_cnt_rst;
  assign STATE   = r_state;
  assign RUNNING = w_run;
  assign OVF     = (r_state == ST_DONE);

  assign DISP1 = (r_state == ST_LAP_RUN) ? r_lap1 : CNT_D1;
  assign DISP2 = (r_state == ST_LAP_RUN) ? r_lap2 : CNT_D2;
  assign DISP3 = (r_state == ST_LAP_RUN) ? r_lap3 : CNT_D3;
  assign DISP4 = (r_state == ST_LAP_RUN) ? r_lap4 : CNT_D4;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a behavioural BCD counter on CNT_EN/CNT_RST.
module tb_stopwatch_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN_SS;
  logic       BTN_LAP;
  logic       BTN_CLR;
  logic [3:0] CNT_D1, CNT_D2, CNT_D3, CNT_D4;
  logic       CNT_EN;
  logic       CNT_RST;
  logic [3:0] DISP1, DISP2, DISP3, DISP4;
  logic [2:0] STATE;
  logic       RUNNING;
  logic       OVF;

  logic [15:0] m_cnt = 16'h0000;
  logic        ld;
  logic [15:0] ld_val;
  logic [15:0] disp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  stopwatch_ctrl #(.TICK_DIV(4), .DEB_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .BTN_SS(BTN_SS), .BTN_LAP(BTN_LAP), .BTN_CLR(BTN_CLR),
    .CNT_D1(CNT_D1), .CNT_D2(CNT_D2), .CNT_D3(CNT_D3), .CNT_D4(CNT_D4),
    .CNT_EN(CNT_EN), .CNT_RST(CNT_RST),
    .DISP1(DISP1), .DISP2(DISP2), .DISP3(DISP3), .DISP4(DISP4),
    .STATE(STATE), .RUNNING(RUNNING), .OVF(OVF)
  );

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    if (ld) m_cnt <= ld_val;
    else if (CNT_RST === 1'b1) m_cnt <= 16'h0000;
    else if (CNT_EN === 1'b1) m_cnt <= bcd_inc(m_cnt);
  end

  assign CNT_D1 = m_cnt[15:12];
  assign CNT_D2 = m_cnt[11:8];
  assign CNT_D3 = m_cnt[7:4];
  assign CNT_D4 = m_cnt[3:0];
  assign disp   = {DISP1, DISP2, DISP3, DISP4};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // b: 0 = SS, 1 = LAP, 2 = CLR
  task automatic press(input int b, input int hold, input int settle);
    case (b)
      0: BTN_SS = 1'b1;
      1: BTN_LAP = 1'b1;
      default: BTN_CLR = 1'b1;
    endcase
    ticks(hold);
    BTN_SS = 1'b0;
    BTN_LAP = 1'b0;
    BTN_CLR = 1'b0;
    ticks(settle);
  endtask

  task automatic test_reset();
    RST = 1'b1; BTN_SS = 1'b0; BTN_LAP = 1'b0; BTN_CLR = 1'b0; ld = 1'b0; ld_val = 16'h0;
    ticks(3);
    n_checks++; if (STATE !== 3'd0) $display("FAIL reset_state got %0d want 0", STATE); else n_pass++;
    n_checks++; if (CNT_EN !== 1'b0) $display("FAIL reset_cnt_en got %b want 0", CNT_EN); else n_pass++;
    n_checks++; if (CNT_RST !== 1'b1) $display("FAIL reset_cnt_rst got %b want 1", CNT_RST); else n_pass++;
    n_checks++; if ({RUNNING, OVF} !== 2'b00) $display("FAIL reset_flags got %b want 00", {RUNNING, OVF}); else n_pass++;
    RST = 1'b0;
    n_checks++; if (CNT_RST !== 1'b1) $display("FAIL reset_rst_hold got %b want 1", CNT_RST); else n_pass++;
    tick();
    n_checks++; if (CNT_RST !== 1'b0) $display("FAIL reset_rst_drop got %b want 0", CNT_RST); else n_pass++;
    n_checks++; if (disp !== 16'h0000) $display("FAIL reset_disp got %h want 0000", disp); else n_pass++;
  endtask

  task automatic test_start();
    logic [12:0] mask;
    BTN_SS = 1'b1;
    ticks(4);
    n_checks++; if (STATE !== 3'd0) $display("FAIL start_early got %0d want 0", STATE); else n_pass++;
    tick();
    n_checks++; if (STATE !== 3'd1) $display("FAIL start_state got %0d want 1", STATE); else n_pass++;
    n_checks++; if (RUNNING !== 1'b1) $display("FAIL start_running got %b want 1", RUNNING); else n_pass++;
    mask = '0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 4) BTN_SS = 1'b0;
      mask[i] = CNT_EN;
    end
    n_checks++; if (mask !== 13'h0888) $display("FAIL start_en_pattern got %h want 0888", mask); else n_pass++;
    n_checks++; if (disp !== 16'h0003) $display("FAIL start_disp got %h want 0003", disp); else n_pass++;
  endtask

  task automatic test_lap();
    int b;
    b = 0;
    while (m_cnt !== 16'h0004 && b < 40) begin tick(); b++; end
    n_checks++; if (m_cnt !== 16'h0004) $display("FAIL lap_wait4 got %h want 0004", m_cnt); else n_pass++;
    BTN_LAP = 1'b1;
    ticks(4);
    BTN_LAP = 1'b0;
    n_checks++; if (STATE !== 3'd1) $display("FAIL lap_pre got %0d want 1", STATE); else n_pass++;
    tick();
    n_checks++; if (STATE !== 3'd3) $display("FAIL lap_state got %0d want 3", STATE); else n_pass++;
    n_checks++; if (disp !== 16'h0005) $display("FAIL lap_snap got %h want 0005", disp); else n_pass++;
    b = 0;
    while (m_cnt !== 16'h0007 && b < 40) begin tick(); b++; end
    n_checks++; if (m_cnt !== 16'h0007) $display("FAIL lap_wait7 got %h want 0007", m_cnt); else n_pass++;
    BTN_LAP = 1'b1;
    ticks(4);
    n_checks++; if (disp !== 16'h0005) $display("FAIL lap_frozen got %h want 0005", disp); else n_pass++;
    tick();
    BTN_LAP = 1'b0;
    n_checks++; if (STATE !== 3'd1) $display("FAIL lap_back got %0d want 1", STATE); else n_pass++;
    n_checks++; if (disp !== 16'h0008) $display("FAIL lap_live got %h want 0008", disp); else n_pass++;
  endtask

  task automatic test_pause_resume();
    int  b;
    logic en_seen;
    b = 0;
    while (CNT_EN !== 1'b1 && b < 20) begin tick(); b++; end
    n_checks++; if (CNT_EN !== 1'b1) $display("FAIL pause_sync got %b want 1", CNT_EN); else n_pass++;
    ticks(2);
    BTN_SS = 1'b1;
    ticks(4);
    BTN_SS = 1'b0;
    tick();
    n_checks++; if (STATE !== 3'd2) $display("FAIL pause_state got %0d want 2", STATE); else n_pass++;
    n_checks++; if (disp !== 16'h0010) $display("FAIL pause_disp got %h want 0010", disp); else n_pass++;
    en_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); en_seen |= CNT_EN; end
    n_checks++; if (en_seen !== 1'b0) $display("FAIL pause_no_en got %b want 0", en_seen); else n_pass++;
    BTN_SS = 1'b1;
    ticks(5);
    BTN_SS = 1'b0;
    n_checks++; if ({STATE, CNT_EN} !== {3'd1, 1'b0}) $display("FAIL resume_state got %0d/%b want 1/0", STATE, CNT_EN); else n_pass++;
    tick();
    n_checks++; if (CNT_EN !== 1'b1) $display("FAIL resume_first_en got %b want 1", CNT_EN); else n_pass++;
    tick();
    n_checks++; if (disp !== 16'h0011) $display("FAIL resume_disp got %h want 0011", disp); else n_pass++;
  endtask

  task automatic test_overflow();
    int b;
    int n_en;
    ld_val = 16'h9998;
    ld = 1'b1;
    tick();
    ld = 1'b0;
    b = 0;
    n_en = 0;
    while (STATE !== 3'd4 && b < 30) begin
      tick();
      b++;
      if (CNT_EN === 1'b1) n_en++;
    end
    n_checks++; if (STATE !== 3'd4) $display("FAIL ovf_state got %0d want 4", STATE); else n_pass++;
    n_checks++; if (n_en !== 1) $display("FAIL ovf_en_count got %0d want 1", n_en); else n_pass++;
    tick();
    n_checks++; if ({OVF, RUNNING, CNT_EN} !== 3'b100) $display("FAIL ovf_flags got %b want 100", {OVF, RUNNING, CNT_EN}); else n_pass++;
    n_checks++; if (disp !== 16'h9999) $display("FAIL ovf_disp got %h want 9999", disp); else n_pass++;
    press(0, 6, 6);
    n_checks++; if (STATE !== 3'd4) $display("FAIL ovf_ss_ignored got %0d want 4", STATE); else n_pass++;
    BTN_CLR = 1'b1;
    ticks(4);
    n_checks++; if (CNT_RST !== 1'b0) $display("FAIL clr_early got %b want 0", CNT_RST); else n_pass++;
    tick();
    BTN_CLR = 1'b0;
    n_checks++; if ({STATE, CNT_RST, CNT_EN} !== {3'd0, 1'b1, 1'b0}) $display("FAIL clr_pulse got %0d/%b/%b want 0/1/0", STATE, CNT_RST, CNT_EN); else n_pass++;
    tick();
    n_checks++; if (CNT_RST !== 1'b0) $display("FAIL clr_one_cycle got %b want 0", CNT_RST); else n_pass++;
    n_checks++; if (disp !== 16'h0000) $display("FAIL clr_disp got %h want 0000", disp); else n_pass++;
    ticks(6);
  endtask

  task automatic test_glitch();
    press(1, 6, 6);
    n_checks++; if (STATE !== 3'd0) $display("FAIL idle_lap_ignored got %0d want 0", STATE); else n_pass++;
    press(0, 6, 6);
    n_checks++; if (STATE !== 3'd1) $display("FAIL glitch_pre got %0d want 1", STATE); else n_pass++;
    BTN_SS = 1'b1;
    tick();
    BTN_SS = 1'b0;
    ticks(10);
    n_checks++; if (STATE !== 3'd1) $display("FAIL glitch_rejected got %0d want 1", STATE); else n_pass++;
  endtask

  task automatic test_priority();
    press(0, 6, 6);
    n_checks++; if (STATE !== 3'd2) $display("FAIL prio_paused got %0d want 2", STATE); else n_pass++;
    BTN_SS = 1'b1;
    BTN_CLR = 1'b1;
    ticks(5);
    BTN_SS = 1'b0;
    BTN_CLR = 1'b0;
    n_checks++; if ({STATE, CNT_RST} !== {3'd0, 1'b1}) $display("FAIL prio_clr_wins got %0d/%b want 0/1", STATE, CNT_RST); else n_pass++;
    ticks(8);
    n_checks++; if ({STATE, CNT_RST} !== {3'd0, 1'b0}) $display("FAIL prio_no_run got %0d/%b want 0/0", STATE, CNT_RST); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_lap();
    test_pause_resume();
    test_overflow();
    test_glitch();
    test_priority();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Controller that sequences the 4-digit BCD counter as a stopwatch.
- Takes three raw push-buttons (START_STOP, LAP, CLEAR) and generates the counter's EN tick pulses and RST pulses.
- Freezes the displayed value for lap times.
- Stops at 9999 instead of wrapping.
- Sits between the board buttons/clock and the counter; its DISP outputs feed the display driver.

Parameters:
TICK_DIV, 100000, CLK cycles per counter increment (min 2)
DEB_CYCLES, 16, consecutive stable synchronized samples required to accept a button level change (min 1)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
BTN_SS  in  1  raw start/stop button, asynchronous
BTN_LAP  in  1  raw lap button, asynchronous
BTN_CLR  in  1  raw clear button, asynchronous
CNT_D1..CNT_D4  in  4 each  live counter digits, D1 = MSB
CNT_EN  out  1  one-CLK-cycle increment pulse to counter EN
CNT_RST  out  1  counter reset pulse
DISP1..DISP4  out  4 each  displayed digits, DISP1 = MSB
STATE  out  3  FSM state encoding
RUNNING  out  1  STATE is RUN or LAP_RUN
OVF  out  1  STATE is DONE

Behaviour:
- Clock and reset: all flops on rising CLK; RST synchronous, overrides everything in the same edge.
- Reset values: STATE=IDLE, CNT_EN=0, CNT_RST=1, prescaler=0, lap regs=0, debounced levels=0.
  - CNT_RST stays 1 while RST is high and for the first cycle after release.
  - A button held through reset is accepted as a press after debounce.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce: the debounced level flips after DEB_CYCLES consecutive synced samples that differ from it.
  - Press = rising edge of the debounced level, one-cycle internal pulse.
  - Raw rise to STATE change is exactly DEB_CYCLES+3 edges.
- Press priority in the same cycle: CLR > SS > LAP. Lower-priority presses in that cycle are dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN/LAP_RUN; holds in PAUSED.
  - Cleared on reset, on an accepted CLR, and on entry to RUN from IDLE.
  - A tick occurs in the cycle the prescaler equals TICK_DIV-1; the prescaler wraps to 0.
  - Tick with digits != 9999: CNT_EN=1 on the following cycle, for one cycle.
  - Tick with all CNT_D* = 4'h9: no CNT_EN, next STATE=DONE.
- FSM:
  - IDLE: SS -> RUN. CLR -> IDLE with CNT_RST pulse. LAP ignored.
  - RUN: SS -> PAUSED. LAP -> LAP_RUN, latching CNT_D1..4 into lap regs. CLR ignored. Terminal tick -> DONE.
  - LAP_RUN: LAP -> RUN. SS -> PAUSED. CLR ignored. Terminal tick -> DONE.
  - PAUSED: SS -> RUN (prescaler resumes its held value). CLR -> IDLE with CNT_RST pulse. LAP ignored.
  - DONE: CLR -> IDLE with CNT_RST pulse. SS and LAP ignored.
- Pulse rules:
  - CNT_RST is a registered 1-cycle pulse the cycle after an accepted CLR.
  - CNT_EN and CNT_RST are never high together.
- Tick in the same cycle as an SS press: the tick's CNT_EN is still issued; the pause then takes effect.
- Lap in the same cycle as a tick: the snapshot holds the pre-increment value.
- DISP1..4:
  - Lap regs in LAP_RUN; CNT_D1..4 passthrough otherwise.
  - Outputs are combinational from registers/inputs; no added latency.
- STATE encoding: IDLE=0, RUN=1, PAUSED=2, LAP_RUN=3, DONE=4. Codes 5-7 are unreachable and recover to IDLE.

Decomposition:
- Shared header/package stopwatch_defs: state encodings, STATE width, BCD_NINE=4'h9, digit width 4.
- One sub-module, btn_debounce (synchronizer + debounce + edge pulse, parameter DEB_CYCLES), instantiated three times.
- FSM, prescaler, lap latch and output mux stay in stopwatch_ctrl.

Test Plan:
Bench uses TICK_DIV=4, DEB_CYCLES=2, and a behavioural 4-digit BCD counter model on CNT_EN/CNT_RST.
- Reset: RST high 3 cycles -> STATE=0, CNT_EN=0, CNT_RST=1 through the first post-reset cycle, then 0; DISP=0000.
- Start: SS press, raw high 10 cycles -> STATE=1 exactly 5 edges after raw rise; CNT_EN pulses every 4 cycles; after 3 pulses DISP=0003.
- Lap: LAP press at count 0005 -> STATE=3, DISP frozen at 0005 while the counter reaches 0008. Second LAP -> STATE=1, DISP=live 0008.
- Pause/resume: SS at prescaler=2 -> STATE=2, no CNT_EN. SS again -> first CNT_EN after 1 cycle of counting; count continues from the held value.
- Overflow: preload counter 9998, run -> one CNT_EN (9999), next tick no CNT_EN, STATE=4, OVF=1, RUNNING=0. SS ignored. CLR -> one CNT_RST pulse, STATE=0, DISP=0000.
- Priority/glitch: CLR and SS pressed same cycle in PAUSED -> IDLE plus CNT_RST, no RUN. In RUN, a 1-cycle raw glitch on BTN_SS is rejected: STATE stays 1.
